// File: rtl/pc_sequencer.sv
// pc_sequencer: three-state PC update engine (IDLE/CALC/DONE); define PC_SEQUENCER_EPC_EN for exception/EPC support
module pc_sequencer #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              beq,
  input  logic              jump,
  input  logic              jr,
  input  logic              exception,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic [25:0]       jump_addr,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic              finish,
  output logic              busy,
  output logic [ADDR_W-1:0] epc
);
`ifdef PC_SEQUENCER_EPC_EN
  localparam bit EPC_ON = 1'b1;
`else
  localparam bit EPC_ON = 1'b0;
  assign epc = '0;
`endif
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic beq_q, jump_q, jr_q, exc_q;
  logic [ADDR_W-1:0] off_q, jrt_q, p4, next_pc;
  logic [25:0] ja_q;
  // next-PC select on captured controls: exception > jr > jump > beq > sequential
  always_comb begin
    p4 = pc + ADDR_W'(4);
    next_pc = (exc_q && EPC_ON) ? ADDR_W'(EXC_VECTOR)
            : jr_q   ? {jrt_q[ADDR_W-1:2], 2'b00}
            : jump_q ? {p4[ADDR_W-1:28], ja_q, 2'b00}
            : beq_q  ? p4 + (off_q << 2)
            : p4;
  end
  // FSM with registered pc/finish/busy; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_VECTOR;
      finish <= 1'b0;
      busy   <= 1'b0;
      beq_q  <= 1'b0;
      jump_q <= 1'b0;
      jr_q   <= 1'b0;
      exc_q  <= 1'b0;
      off_q  <= '0;
      jrt_q  <= '0;
      ja_q   <= '0;
`ifdef PC_SEQUENCER_EPC_EN
      epc    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          beq_q  <= beq;
          jump_q <= jump;
          jr_q   <= jr;
          exc_q  <= exception;
          off_q  <= branch_offset;
          jrt_q  <= jr_target;
          ja_q   <= jump_addr;
          state  <= CALC;
          busy   <= 1'b1;
        end
        CALC: if (!stall) begin
          pc     <= next_pc;
          state  <= DONE;
          finish <= 1'b1;
`ifdef PC_SEQUENCER_EPC_EN
          if (exc_q) epc <= p4;
`endif
        end
        DONE: begin
          state  <= IDLE;
          finish <= 1'b0;
          busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          finish <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer (honours PC_SEQUENCER_EPC_EN)
module tb_pc_sequencer;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset, start, stall, beq, jump, jr, exception, finish, busy;
  logic [W-1:0] branch_offset, jr_target, pc, epc, pc0, epc_now;
  logic [25:0] jump_addr;
  typedef struct {logic [W-1:0] pc; logic [W-1:0] epc;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, fails = 0;

  pc_sequencer #(.ADDR_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .beq(beq), .jump(jump),
    .jr(jr), .exception(exception), .branch_offset(branch_offset), .jump_addr(jump_addr),
    .jr_target(jr_target), .pc(pc), .finish(finish), .busy(busy), .epc(epc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every finish pulse must match the oldest expected result
  always @(negedge clk) begin
    if (finish === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_underflow: got finish=1 expected no pending result");
      end else begin
        mon_e = sb.pop_front();
        check("pc", {32'h0, pc}, {32'h0, mon_e.pc});
        check("epc", {32'h0, epc}, {32'h0, mon_e.epc});
      end
    end
  end

  task automatic op(input logic b, j, r, x, input logic [W-1:0] off, input logic [25:0] ja,
                    input logic [W-1:0] jt, input logic [W-1:0] exp_pc, input int n_stall);
    @(negedge clk);
    beq = b; jump = j; jr = r; exception = x;
    branch_offset = off; jump_addr = ja; jr_target = jt;
    start = 1'b1;
    stall = (n_stall > 0);
    pc0 = pc;
    sb.push_back('{exp_pc, epc_now});
    @(posedge clk); #1;
    check("busy_calc", {62'h0, finish, busy}, 64'h1);
    start = 1'b0;
    beq = 1'($urandom); jump = 1'($urandom); jr = 1'($urandom); exception = 1'($urandom);
    branch_offset = $urandom; jump_addr = 26'($urandom); jr_target = $urandom;
    for (int i = 0; i < n_stall; i++) begin
      @(posedge clk); #1;
      check("stall_hold", {62'h0, finish, busy}, 64'h1);
      check("stall_pc", {32'h0, pc}, {32'h0, pc0});
      start = 1'b1;
      if (i == n_stall - 1) stall = 1'b0;
    end
    @(posedge clk); #1;
    check("finish_lat", {62'h0, finish, busy}, 64'h3);
    start = 1'b1;
    @(posedge clk); #1;
    check("done_exit", {62'h0, finish, busy}, 64'h0);
    start = 1'b0;
    @(posedge clk); #1;
    check("no_queue", {62'h0, finish, busy}, 64'h0);
    check("idle_pc", {32'h0, pc}, {32'h0, exp_pc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; beq = 1'b0; jump = 1'b0; jr = 1'b0;
    exception = 1'b0; branch_offset = '0; jump_addr = '0; jr_target = '0; epc_now = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", {32'h0, pc}, 64'h0);
    check("rst_flags", {62'h0, finish, busy}, 64'h0);
    check("rst_epc", {32'h0, epc}, 64'h0);
    @(negedge clk) reset = 1'b0;
    op(0, 0, 0, 0, '0, '0, '0, 32'h4, 0);
    op(0, 0, 1, 0, '0, '0, 32'h10, 32'h10, 0);
    op(1, 0, 0, 0, 32'hFFFF_FFFE, '0, '0, 32'h0C, 0);
    op(0, 0, 1, 0, '0, '0, 32'h10, 32'h10, 0);
    op(1, 0, 0, 0, 32'h3, '0, '0, 32'h20, 0);
    op(0, 0, 1, 0, '0, '0, 32'h1000_0008, 32'h1000_0008, 0);
    op(0, 1, 0, 0, '0, 26'h40, '0, 32'h1000_0100, 0);
    op(0, 0, 1, 0, '0, '0, 32'h1000_0008, 32'h1000_0008, 0);
    op(0, 1, 1, 0, '0, 26'h40, 32'h203, 32'h200, 0);
    op(1, 1, 0, 0, 32'h5, 26'h10, '0, 32'h40, 0);
    op(0, 0, 1, 0, '0, '0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
    op(0, 0, 0, 0, '0, '0, '0, 32'h0, 3);
    op(0, 0, 1, 0, '0, '0, 32'h40, 32'h40, 0);
`ifdef PC_SEQUENCER_EPC_EN
    epc_now = 32'h44;
    op(0, 1, 0, 1, '0, 26'h100, '0, 32'h80, 0);
`else
    op(0, 1, 0, 1, '0, 26'h100, '0, 32'h400, 0);
`endif
    @(negedge clk);
    beq = 1'b0; jump = 1'b0; jr = 1'b1; exception = 1'b0; jr_target = 32'h300;
    start = 1'b1; stall = 1'b1;
    @(posedge clk); #1;
    check("rst_calc_busy", {62'h0, finish, busy}, 64'h1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_pc", {32'h0, pc}, 64'h0);
    check("rst_mid_flags", {62'h0, finish, busy}, 64'h0);
    check("rst_mid_epc", {32'h0, epc}, 64'h0);
    @(posedge clk); #1;
    check("rst_start_held", {62'h0, finish, busy}, 64'h0);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; jr = 1'b0; epc_now = '0;
    sb.push_back('{32'h4, 32'h0});
    @(posedge clk); #1;
    check("post_rst_accept", {62'h0, finish, busy}, 64'h1);
    start = 1'b0;
    @(posedge clk); #1;
    check("post_rst_finish", {62'h0, finish, busy}, 64'h3);
    @(posedge clk); #1;
    check("sb_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
